game_flow_ctrl: RTL and testbench
=================================

Name: game_flow_ctrl

Overview:
Top-level game sequencer that owns the overall game state and every substate: menu, difficulty selection, timed map reveal, hidden-map gap, play, lost and won. It consumes single-cycle button pulses and the collision and goal flags from the player/map datapath. It drives the enables that gate player movement and map rendering, plus a player-position reset pulse. It sits between the button debouncers and the player/collision/renderer logic.

Parameters:
SHOW_EASY, 150000000, map-visible duration in cycles, easy
SHOW_MEDIUM, 100000000, map-visible duration in cycles, medium
SHOW_HARD, 50000000, map-visible duration in cycles, hard
HIDE_CYCLES, 25000000, blank gap between reveal and play
LIVES, 3, starting lives (used only with GAME_LIVES_EN)
TW, 32, timer counter width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
btn_up/btn_down/btn_left/btn_right/btn_center  in  1 each  one-cycle debounced pulses
collision  in  1  player overlaps a wall (level, sampled each cycle)
goal  in  1  player on goal tile (level)
game_state  out  4  one-hot: MENU=0001, GAME=0010, LOST=0100, WON=1000
game_sub  out  3  in GAME: SHOW=001, HIDE=010, PLAY=100; 000 otherwise
menu_sel  out  3  START=001, DIFF=010, INSTR=100
difficulty  out  3  EASY=001, MEDIUM=010, HARD=100
show_instr  out  1  instructions overlay active
map_visible  out  1  renderer shows walls
move_en  out  1  player movement allowed
player_rst  out  1  one-cycle pulse: zero player position
lost, won  out  1  sticky result flags
lives  out  2  remaining lives

Behaviour:
- All outputs are registered; updates take effect the cycle after the causing input.
- Reset (reset==0 at a clk edge) values, applied from any state including mid-timer:
  - game_state=MENU, game_sub=000, menu_sel=START, difficulty=EASY
  - show_instr=0, map_visible=0, move_en=0, player_rst=0, lost=0, won=0
  - timer=0; lives=LIVES with GAME_LIVES_EN, else 0
- MENU behaviour:
  - btn_down rotates menu_sel START→DIFF→INSTR→START; btn_up rotates the reverse way.
  - btn_left/btn_right rotate difficulty down/up with wrap, only while menu_sel=DIFF.
  - btn_center on INSTR toggles show_instr.
  - btn_center on START: clear show_instr, pulse player_rst, reload lives, go GAME/SHOW, timer=0.
  - btn_center on DIFF: no effect.
  - Simultaneous pulses use priority center > up > down > left > right; one action per cycle.
- GAME/SHOW:
  - map_visible=1, move_en=0.
  - timer increments each cycle; at timer==N-1 go HIDE with timer=0. N is selected by the difficulty latched at entry, so SHOW lasts exactly N cycles.
- GAME/HIDE:
  - map_visible=0, move_en=0; lasts exactly HIDE_CYCLES cycles, then PLAY.
- GAME/PLAY:
  - move_en=1, map_visible=0.
  - collision → LOST with lost=1.
  - goal (no collision) → WON with won=1.
  - collision and goal in the same cycle → LOST (collision has priority).
- Ignored inputs:
  - All buttons are ignored in SHOW/HIDE/PLAY.
  - collision/goal are ignored outside PLAY.
- LOST/WON:
  - move_en=0, map_visible=1 (reveal the maze).
  - btn_center → MENU, clears lost/won, menu_sel=START, difficulty retained.
- Timer never wraps; it is cleared on every state change.
- Difficulty changes are impossible during GAME.

Optional Feature:
GAME_LIVES_EN:
- Defined:
  - A collision in PLAY with lives>1 decrements lives, pulses player_rst and returns to SHOW with timer=0.
  - A collision with lives==1 sets lives=0 and goes to LOST.
- Undefined:
  - Any collision in PLAY goes to LOST; the lives output is tied to 0 and there is no lives register.

Decomposition:
- Package game_pkg: state/substate/menu/difficulty one-hot localparams, TW default, priority encoding of buttons.
- Sub-module phase_timer:
  - Clear-able up-counter with a terminal-count compare input N and a one-cycle done output.
  - Instantiated once and reused for SHOW and HIDE.

Test Plan:
(Benches override SHOW_EASY=8, SHOW_MEDIUM=5, SHOW_HARD=3, HIDE_CYCLES=2, LIVES=2.)
1. Reset, then btn_down×2, btn_up×1 → menu_sel 001→010→100→010; btn_right×2 → difficulty 001→010→100; btn_right → 001 (wrap).
2. Select HARD, btn_center on START → player_rst high for 1 cycle; SHOW (map_visible=1) for exactly 3 cycles; HIDE 2 cycles; then PLAY with move_en=1.
3. In PLAY assert collision and goal in the same cycle → next cycle game_state=0100, lost=1, won=0, move_en=0; btn_center → MENU, lost=0, difficulty still HARD.
4. EASY run, goal in PLAY → WON, won=1; buttons pulsed during SHOW/HIDE leave menu_sel and difficulty unchanged.
5. reset low for one cycle in the middle of SHOW (timer=4) → all outputs equal their reset values on the next cycle.
6. With GAME_LIVES_EN, first collision in PLAY → lives 2→1, player_rst pulse, back to SHOW; second collision → lives=0, LOST. Without the macro, the first collision → LOST and lives=0 throughout.

Source files
------------

// File: rtl/game_pkg.sv
// Shared encodings and helpers for the game flow sequencer.
// Latency: none. The package holds only constants and pure functions.
// Backpressure: none. Button pulses are consumed on the cycle they arrive.
package game_pkg;

  localparam int TW_DEF = 32;

  // One-hot top-level state as seen by the renderer.
  localparam logic [3:0] GS_MENU = 4'b0001;
  localparam logic [3:0] GS_GAME = 4'b0010;
  localparam logic [3:0] GS_LOST = 4'b0100;
  localparam logic [3:0] GS_WON  = 4'b1000;

  // One-hot substate inside GAME.
  localparam logic [2:0] SUB_NONE = 3'b000;
  localparam logic [2:0] SUB_SHOW = 3'b001;
  localparam logic [2:0] SUB_HIDE = 3'b010;
  localparam logic [2:0] SUB_PLAY = 3'b100;

  // One-hot menu cursor.
  localparam logic [2:0] SEL_START = 3'b001;
  localparam logic [2:0] SEL_DIFF  = 3'b010;
  localparam logic [2:0] SEL_INSTR = 3'b100;

  // One-hot difficulty.
  localparam logic [2:0] DIFF_EASY   = 3'b001;
  localparam logic [2:0] DIFF_MEDIUM = 3'b010;
  localparam logic [2:0] DIFF_HARD   = 3'b100;

  // Internal sequencer state; the one-hot outputs are decoded from this.
  typedef enum logic [2:0] {
    ST_MENU,
    ST_SHOW,
    ST_HIDE,
    ST_PLAY,
    ST_LOST,
    ST_WON
  } flow_state_t;

  // The single button action honoured in a cycle.
  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_CENTER,
    ACT_UP,
    ACT_DOWN,
    ACT_LEFT,
    ACT_RIGHT
  } btn_act_t;

  // Simultaneous pulses collapse to one action: center > up > down > left > right.
  function automatic btn_act_t btn_priority(input logic center, input logic up,
                                            input logic down, input logic left,
                                            input logic right);
    btn_act_t act;
    act = ACT_NONE;
    if (center)     act = ACT_CENTER;
    else if (up)    act = ACT_UP;
    else if (down)  act = ACT_DOWN;
    else if (left)  act = ACT_LEFT;
    else if (right) act = ACT_RIGHT;
    return act;
  endfunction

  // Advance a 3-bit one-hot value: 001 -> 010 -> 100 -> 001.
  function automatic logic [2:0] rot_fwd(input logic [2:0] v);
    return {v[1:0], v[2]};
  endfunction

  // Step a 3-bit one-hot value back: 001 -> 100 -> 010 -> 001.
  function automatic logic [2:0] rot_back(input logic [2:0] v);
    return {v[0], v[2:1]};
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Clearable up-counter with a one-cycle done at count == n-1; shared by SHOW and HIDE.
// Latency: done is combinational from the count register; clear takes effect next cycle.
// Backpressure: none. The counter holds at n-1 rather than wrapping if done is not acted on.
module phase_timer
  import game_pkg::*;
#(
  parameter int TW = TW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  input  logic [TW-1:0] n,
  output logic          done
);

  logic [TW-1:0] count;

  assign done = en && (count == (n - TW'(1)));

  // Count while enabled, stop at the terminal value, clear on request or reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !done) begin
      count <= count + TW'(1);
    end
  end

endmodule

// File: rtl/game_flow_ctrl.sv
// Game sequencer: menu, difficulty, timed map reveal, hidden gap, play, lost/won; optional GAME_LIVES_EN adds lives.
// Latency: every output is registered and reflects the causing input one cycle later.
// Backpressure: none. Button pulses and collision/goal levels are acted on or dropped in the cycle seen.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int SHOW_EASY   = 150000000,
  parameter int SHOW_MEDIUM = 100000000,
  parameter int SHOW_HARD   = 50000000,
  parameter int HIDE_CYCLES = 25000000,
  parameter int LIVES       = 3,
  parameter int TW          = TW_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_center,
  input  logic       collision,
  input  logic       goal,
  output logic [3:0] game_state,
  output logic [2:0] game_sub,
  output logic [2:0] menu_sel,
  output logic [2:0] difficulty,
  output logic       show_instr,
  output logic       map_visible,
  output logic       move_en,
  output logic       player_rst,
  output logic       lost,
  output logic       won,
  output logic [1:0] lives
);

  localparam logic [TW-1:0] N_EASY   = TW'(SHOW_EASY);
  localparam logic [TW-1:0] N_MEDIUM = TW'(SHOW_MEDIUM);
  localparam logic [TW-1:0] N_HARD   = TW'(SHOW_HARD);
  localparam logic [TW-1:0] N_HIDE   = TW'(HIDE_CYCLES);

  flow_state_t   state, state_d;
  btn_act_t      act;
  logic [2:0]    menu_sel_d, difficulty_d;
  logic          show_instr_d, player_rst_d;
  logic [3:0]    game_state_d;
  logic [2:0]    game_sub_d;
  logic          map_visible_d, move_en_d, lost_d, won_d;
  logic [TW-1:0] show_len, timer_n;
  logic          timer_en, timer_clr, timer_done;

`ifdef GAME_LIVES_EN
  localparam logic [1:0] LIVES_INIT = 2'(LIVES);
  logic [1:0] lives_q, lives_d;
  assign lives = lives_q;
`else
  assign lives = 2'b00;
`endif

  assign act = btn_priority(btn_center, btn_up, btn_down, btn_left, btn_right);

  // Reveal length follows difficulty; difficulty is frozen for the whole GAME phase,
  // so this is effectively the value latched when the run started.
  always_comb begin
    show_len = N_EASY;
    case (difficulty)
      DIFF_MEDIUM: show_len = N_MEDIUM;
      DIFF_HARD:   show_len = N_HARD;
      default:     show_len = N_EASY;
    endcase
  end

  assign timer_en  = (state == ST_SHOW) || (state == ST_HIDE);
  assign timer_n   = (state == ST_HIDE) ? N_HIDE : show_len;
  assign timer_clr = (state_d != state);

  phase_timer #(
    .TW (TW)
  ) u_phase_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (timer_clr),
    .en    (timer_en),
    .n     (timer_n),
    .done  (timer_done)
  );

  // Next-state and next-value logic for the sequencer and menu registers.
  always_comb begin
    state_d      = state;
    menu_sel_d   = menu_sel;
    difficulty_d = difficulty;
    show_instr_d = show_instr;
    player_rst_d = 1'b0;
`ifdef GAME_LIVES_EN
    lives_d      = lives_q;
`endif
    case (state)
      ST_MENU: begin
        case (act)
          ACT_CENTER: begin
            if (menu_sel == SEL_INSTR) begin
              show_instr_d = ~show_instr;
            end else if (menu_sel == SEL_START) begin
              show_instr_d = 1'b0;
              player_rst_d = 1'b1;
              state_d      = ST_SHOW;
`ifdef GAME_LIVES_EN
              lives_d      = LIVES_INIT;
`endif
            end
          end
          ACT_UP:    menu_sel_d = rot_back(menu_sel);
          ACT_DOWN:  menu_sel_d = rot_fwd(menu_sel);
          ACT_LEFT:  if (menu_sel == SEL_DIFF) difficulty_d = rot_back(difficulty);
          ACT_RIGHT: if (menu_sel == SEL_DIFF) difficulty_d = rot_fwd(difficulty);
          default: ;
        endcase
      end
      ST_SHOW: if (timer_done) state_d = ST_HIDE;
      ST_HIDE: if (timer_done) state_d = ST_PLAY;
      ST_PLAY: begin
        if (collision) begin
`ifdef GAME_LIVES_EN
          if (lives_q > 2'd1) begin
            lives_d      = lives_q - 2'd1;
            player_rst_d = 1'b1;
            state_d      = ST_SHOW;
          end else begin
            lives_d = 2'd0;
            state_d = ST_LOST;
          end
`else
          state_d = ST_LOST;
`endif
        end else if (goal) begin
          state_d = ST_WON;
        end
      end
      ST_LOST, ST_WON: begin
        if (act == ACT_CENTER) begin
          state_d    = ST_MENU;
          menu_sel_d = SEL_START;
        end
      end
      default: state_d = ST_MENU;
    endcase
  end

  // Decode the one-hot outputs and gating enables from the upcoming state.
  always_comb begin
    game_state_d  = GS_MENU;
    game_sub_d    = SUB_NONE;
    map_visible_d = 1'b0;
    move_en_d     = 1'b0;
    lost_d        = 1'b0;
    won_d         = 1'b0;
    case (state_d)
      ST_SHOW: begin
        game_state_d  = GS_GAME;
        game_sub_d    = SUB_SHOW;
        map_visible_d = 1'b1;
      end
      ST_HIDE: begin
        game_state_d = GS_GAME;
        game_sub_d   = SUB_HIDE;
      end
      ST_PLAY: begin
        game_state_d = GS_GAME;
        game_sub_d   = SUB_PLAY;
        move_en_d    = 1'b1;
      end
      ST_LOST: begin
        game_state_d  = GS_LOST;
        map_visible_d = 1'b1;
        lost_d        = 1'b1;
      end
      ST_WON: begin
        game_state_d  = GS_WON;
        map_visible_d = 1'b1;
        won_d         = 1'b1;
      end
      default: ;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_MENU;
      game_state  <= GS_MENU;
      game_sub    <= SUB_NONE;
      menu_sel    <= SEL_START;
      difficulty  <= DIFF_EASY;
      show_instr  <= 1'b0;
      map_visible <= 1'b0;
      move_en     <= 1'b0;
      player_rst  <= 1'b0;
      lost        <= 1'b0;
      won         <= 1'b0;
`ifdef GAME_LIVES_EN
      lives_q     <= LIVES_INIT;
`endif
    end else begin
      state       <= state_d;
      game_state  <= game_state_d;
      game_sub    <= game_sub_d;
      menu_sel    <= menu_sel_d;
      difficulty  <= difficulty_d;
      show_instr  <= show_instr_d;
      map_visible <= map_visible_d;
      move_en     <= move_en_d;
      player_rst  <= player_rst_d;
      lost        <= lost_d;
      won         <= won_d;
`ifdef GAME_LIVES_EN
      lives_q     <= lives_d;
`endif
    end
  end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Testbench for game_flow_ctrl: directed scenarios then random stimulus against a reference model.
// Latency: outputs are compared one cycle after each input vector is applied.
// Backpressure: none.
module tb_game_flow_ctrl;

  localparam int P_EASY  = 8;
  localparam int P_MED   = 5;
  localparam int P_HARD  = 3;
  localparam int P_HIDE  = 2;
  localparam int P_LIVES = 2;
`ifdef GAME_LIVES_EN
  localparam bit LIVES_ON = 1'b1;
`else
  localparam bit LIVES_ON = 1'b0;
`endif

  localparam int M_MENU = 0, M_SHOW = 1, M_HIDE = 2, M_PLAY = 3, M_LOST = 4, M_WON = 5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_center = 1'b0;
  logic collision = 1'b0, goal = 1'b0;
  logic [3:0] game_state;
  logic [2:0] game_sub, menu_sel, difficulty;
  logic       show_instr, map_visible, move_en, player_rst, lost, won;
  logic [1:0] lives;

  game_flow_ctrl #(
    .SHOW_EASY   (P_EASY),
    .SHOW_MEDIUM (P_MED),
    .SHOW_HARD   (P_HARD),
    .HIDE_CYCLES (P_HIDE),
    .LIVES       (P_LIVES),
    .TW          (32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .btn_center  (btn_center),
    .collision   (collision),
    .goal        (goal),
    .game_state  (game_state),
    .game_sub    (game_sub),
    .menu_sel    (menu_sel),
    .difficulty  (difficulty),
    .show_instr  (show_instr),
    .map_visible (map_visible),
    .move_en     (move_en),
    .player_rst  (player_rst),
    .lost        (lost),
    .won         (won),
    .lives       (lives)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: mode, cycles left in the timed phase, cursor/difficulty indices.
  int m_mode  = M_MENU;
  int m_left  = 0;
  int m_sel   = 0;
  int m_diff  = 0;
  int m_lives = 0;
  bit m_instr = 1'b0;
  bit m_prst  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int reveal_len(input int d);
    if (d == 0) return P_EASY;
    if (d == 1) return P_MED;
    return P_HARD;
  endfunction

  function automatic logic [20:0] dut_vec();
    return {game_state, game_sub, menu_sel, difficulty, show_instr, map_visible,
            move_en, player_rst, lost, won, lives};
  endfunction

  function automatic logic [20:0] model_vec();
    logic [3:0] gs;
    logic [2:0] sub;
    bit in_game, vis;
    in_game = (m_mode >= M_SHOW) && (m_mode <= M_PLAY);
    gs  = (m_mode == M_MENU) ? 4'd1 : in_game ? 4'd2 : (m_mode == M_LOST) ? 4'd4 : 4'd8;
    sub = (m_mode == M_SHOW) ? 3'd1 : (m_mode == M_HIDE) ? 3'd2 : (m_mode == M_PLAY) ? 3'd4 : 3'd0;
    vis = (m_mode == M_SHOW) || (m_mode == M_LOST) || (m_mode == M_WON);
    return {gs, sub, 3'(1 << m_sel), 3'(1 << m_diff), m_instr, vis,
            (m_mode == M_PLAY), m_prst, (m_mode == M_LOST), (m_mode == M_WON), 2'(m_lives)};
  endfunction

  task automatic model_step(input bit rst, input bit c, input bit u, input bit d,
                            input bit l, input bit r, input bit col, input bit gl);
    if (!rst) begin
      m_mode = M_MENU; m_left = 0; m_sel = 0; m_diff = 0;
      m_instr = 1'b0; m_prst = 1'b0; m_lives = LIVES_ON ? P_LIVES : 0;
      return;
    end
    m_prst = 1'b0;
    case (m_mode)
      M_MENU: begin
        if (c) begin
          if (m_sel == 2) m_instr = !m_instr;
          else if (m_sel == 0) begin
            m_instr = 1'b0; m_prst = 1'b1; m_mode = M_SHOW; m_left = reveal_len(m_diff);
            m_lives = LIVES_ON ? P_LIVES : 0;
          end
        end else if (u) m_sel = (m_sel + 2) % 3;
        else if (d) m_sel = (m_sel + 1) % 3;
        else if (l) begin if (m_sel == 1) m_diff = (m_diff + 2) % 3; end
        else if (r) begin if (m_sel == 1) m_diff = (m_diff + 1) % 3; end
      end
      M_SHOW: begin
        m_left--;
        if (m_left == 0) begin m_mode = M_HIDE; m_left = P_HIDE; end
      end
      M_HIDE: begin
        m_left--;
        if (m_left == 0) m_mode = M_PLAY;
      end
      M_PLAY: begin
        if (col) begin
          if (LIVES_ON && m_lives > 1) begin
            m_lives--; m_prst = 1'b1; m_mode = M_SHOW; m_left = reveal_len(m_diff);
          end else begin
            m_lives = 0; m_mode = M_LOST;
          end
        end else if (gl) m_mode = M_WON;
      end
      default: begin
        if (c) begin m_mode = M_MENU; m_sel = 0; end
      end
    endcase
  endtask

  // Apply one input vector (called at a falling edge), advance the model, compare at the next falling edge.
  task automatic tick(input string tag, input bit rst, input bit c, input bit u, input bit d,
                      input bit l, input bit r, input bit col, input bit gl);
    reset = rst; btn_center = c; btn_up = u; btn_down = d;
    btn_left = l; btn_right = r; collision = col; goal = gl;
    model_step(rst, c, u, d, l, r, col, gl);
    @(negedge clk);
    check(tag, 32'(dut_vec()), 32'(model_vec()));
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) tick(tag, 1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [20:0] rst_vec;
    rst_vec = {4'b0001, 3'b000, 3'b001, 3'b001, 6'b000000, LIVES_ON ? 2'd2 : 2'd0};

    // Reset state
    tick("rst", 0, 0, 0, 0, 0, 0, 0, 0);
    tick("rst", 0, 0, 0, 0, 0, 0, 0, 0);
    check("rst_vec", 32'(dut_vec()), 32'(rst_vec));

    // Menu cursor and difficulty rotation
    tick("t1", 1, 0, 0, 1, 0, 0, 0, 0); check("t1_sel_down1", menu_sel, 3'b010);
    tick("t1", 1, 0, 0, 1, 0, 0, 0, 0); check("t1_sel_down2", menu_sel, 3'b100);
    tick("t1", 1, 0, 1, 0, 0, 0, 0, 0); check("t1_sel_up", menu_sel, 3'b010);
    tick("t1", 1, 0, 0, 0, 0, 1, 0, 0); check("t1_diff_r1", difficulty, 3'b010);
    tick("t1", 1, 0, 0, 0, 0, 1, 0, 0); check("t1_diff_r2", difficulty, 3'b100);
    tick("t1", 1, 0, 0, 0, 0, 1, 0, 0); check("t1_diff_wrap", difficulty, 3'b001);

    // HARD run: reveal 3 cycles, hide 2, then play
    tick("t2", 1, 0, 0, 0, 1, 0, 0, 0); check("t2_diff_hard", difficulty, 3'b100);
    tick("t2", 1, 0, 1, 0, 0, 0, 0, 0); check("t2_sel_start", menu_sel, 3'b001);
    tick("t2", 1, 1, 0, 0, 0, 0, 0, 0);
    check("t2_prst_pulse", player_rst, 1'b1);
    check("t2_show0", {game_state, game_sub, map_visible}, {4'b0010, 3'b001, 1'b1});
    idle("t2", 1); check("t2_prst_off", player_rst, 1'b0); check("t2_show1", game_sub, 3'b001);
    idle("t2", 1); check("t2_show2", game_sub, 3'b001);
    idle("t2", 1); check("t2_hide0", {game_sub, map_visible}, {3'b010, 1'b0});
    idle("t2", 1); check("t2_hide1", game_sub, 3'b010);
    idle("t2", 1); check("t2_play", {game_sub, move_en}, {3'b100, 1'b1});

`ifdef GAME_LIVES_EN
    tick("t6", 1, 0, 0, 0, 0, 0, 1, 0);
    check("t6_lives1", lives, 2'd1);
    check("t6_prst", player_rst, 1'b1);
    check("t6_reshow", game_sub, 3'b001);
    idle("t6", 5); check("t6_play_again", game_sub, 3'b100);
    tick("t3", 1, 0, 0, 0, 0, 0, 1, 1);
    check("t6_lives0", lives, 2'd0);
`else
    tick("t3", 1, 0, 0, 0, 0, 0, 1, 1);
    check("t6_lives0", lives, 2'd0);
`endif
    check("t3_lost", {game_state, lost, won, move_en, map_visible}, {4'b0100, 1'b1, 1'b0, 1'b0, 1'b1});
    tick("t3", 1, 1, 0, 0, 0, 0, 0, 0);
    check("t3_menu", {game_state, lost, menu_sel}, {4'b0001, 1'b0, 3'b001});
    check("t3_diff_kept", difficulty, 3'b100);

    // EASY run with buttons pulsed during reveal/hide, then goal
    tick("t4", 1, 0, 0, 1, 0, 0, 0, 0);
    tick("t4", 1, 0, 0, 0, 0, 1, 0, 0); check("t4_diff_easy", difficulty, 3'b001);
    tick("t4", 1, 0, 1, 0, 0, 0, 0, 0);
    tick("t4", 1, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      logic [6:0] b;
      b = 7'($urandom);
      tick("t4_ignored", 1, b[0], b[1], b[2], b[3], b[4], b[5], b[6]);
    end
    check("t4_sel_kept", menu_sel, 3'b001);
    check("t4_diff_kept", difficulty, 3'b001);
    check("t4_play", {game_sub, move_en}, {3'b100, 1'b1});
    tick("t4", 1, 0, 0, 0, 0, 0, 0, 1);
    check("t4_won", {game_state, won, lost}, {4'b1000, 1'b1, 1'b0});
    tick("t4", 1, 1, 0, 0, 0, 0, 0, 0);

    // Reset in the middle of a reveal
    tick("t5", 1, 1, 0, 0, 0, 0, 0, 0);
    idle("t5", 4); check("t5_mid_show", game_sub, 3'b001);
    tick("t5", 0, 0, 0, 0, 0, 0, 0, 0);
    check("t5_rst_vec", 32'(dut_vec()), 32'(rst_vec));
    idle("t5", 1);

    // Random stimulus against the model
    for (int i = 0; i < 4000 && n_fail <= 20; i++) begin
      bit rst, c, u, d, l, r, col, gl;
      rst = ($urandom_range(0, 299) != 0);
      c   = ($urandom_range(0, 9) == 0);
      u   = ($urandom_range(0, 7) == 0);
      d   = ($urandom_range(0, 7) == 0);
      l   = ($urandom_range(0, 7) == 0);
      r   = ($urandom_range(0, 7) == 0);
      col = ($urandom_range(0, 11) == 0);
      gl  = ($urandom_range(0, 11) == 0);
      tick("rand", rst, c, u, d, l, r, col, gl);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
